// File: rtl/cv32e40p_x_resp_copro.sv
// Coprocessor responder for the core's X offload interface: decodes custom-0 ops, queues results, returns them in order.
// Optional macro X_RESP_ILLEGAL_ERR_EN: accept funct3 110/111 and answer them with an error response.
`timescale 1ns/1ps
module cv32e40p_x_resp_copro #(
  parameter int         DEPTH   = 4,
  parameter int         LATENCY = 2,
  parameter logic [6:0] OPCODE  = 7'h0B
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             x_valid_i,
  output logic             x_ready_o,
  input  logic [31:0]      x_instr_data_i,
  input  logic [2:0][31:0] x_rs_i,
  input  logic [2:0]       x_rs_valid_i,
  input  logic             x_rd_clean_i,
  output logic             x_accept_o,
  output logic             x_is_mem_op_o,
  output logic             x_writeback_o,
  output logic             x_rvalid_o,
  input  logic             x_rready_i,
  output logic [4:0]       x_rd_o,
  output logic [31:0]      x_data_o,
  output logic             x_dualwb_o,
  output logic             x_type_o,
  output logic             x_error_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] TIMER_INIT = 4'(LATENCY - 1);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] rs1, rs2, rs3, result;
  logic        illegal, hit, err, need_rs3, ops_ok;
  logic        full, empty, push, pop;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic [4:0]  rd_q    [DEPTH];
  logic [31:0] data_q  [DEPTH];
  logic        err_q   [DEPTH];
  logic [3:0]  timer_q [DEPTH];

  logic unused;
  assign unused = ^x_instr_data_i[31:15];

  assign opcode = x_instr_data_i[6:0];
  assign rd     = x_instr_data_i[11:7];
  assign f3     = x_instr_data_i[14:12];
  assign rs1    = x_rs_i[0];
  assign rs2    = x_rs_i[1];
  assign rs3    = x_rs_i[2];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (f3)
      3'b000:  result = rs1 + rs2;
      3'b001:  result = rs1 - rs2;
      3'b010:  result = rs1 ^ rs2;
      3'b011:  result = ($signed(rs1) < $signed(rs2)) ? rs1 : rs2;
      3'b100:  result = (rs1 > rs2) ? rs1 : rs2;
      3'b101:  result = (rs1 * rs2) + rs3;
      default: illegal = 1'b1;
    endcase
  end

`ifdef X_RESP_ILLEGAL_ERR_EN
  assign hit = (opcode == OPCODE);
  assign err = illegal;
`else
  assign hit = (opcode == OPCODE) && !illegal;
  assign err = 1'b0;
`endif

  assign need_rs3 = (f3 == 3'b101);
  assign ops_ok   = x_rs_valid_i[0] && x_rs_valid_i[1] && (!need_rs3 || x_rs_valid_i[2]);

  // full looks only at the registered count, so a same-cycle pop never frees a slot early
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign x_ready_o     = hit ? (!full && ops_ok && x_rd_clean_i) : 1'b1;
  assign x_accept_o    = hit;
  assign x_writeback_o = hit;
  assign x_is_mem_op_o = 1'b0;
  assign x_dualwb_o    = 1'b0;
  assign x_type_o      = 1'b0;

  assign push = x_valid_i && x_ready_o && hit;

  assign x_rvalid_o = !empty && (timer_q[rptr] == 4'd0);
  assign pop        = x_rvalid_o && x_rready_i;

  assign x_rd_o    = empty ? 5'd0  : rd_q[rptr];
  assign x_data_o  = empty ? 32'd0 : data_q[rptr];
  assign x_error_o = empty ? 1'b0  : err_q[rptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
        err_q[i]   <= 1'b0;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (timer_q[i] != 4'd0) timer_q[i] <= timer_q[i] - 4'd1;
      end
      // the push write below overrides the decrement of the slot it lands in
      if (push) begin
        rd_q[wptr]    <= rd;
        data_q[wptr]  <= err ? 32'd0 : result;
        err_q[wptr]   <= err;
        timer_q[wptr] <= TIMER_INIT;
        wptr          <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
